// File: rtl/mips_disp_pkg.sv
// mips_disp_pkg
//   Shared definitions for the mips_disp_scanner debug display consumer:
//   mode encodings, address wrap limits, and the active-low hex-to-7-segment
//   table (segment order gfedcba, bit 6 = g).
package mips_disp_pkg;

  localparam logic [1:0] MODE_PC  = 2'b00;
  localparam logic [1:0] MODE_REG = 2'b01;
  localparam logic [1:0] MODE_MEM = 2'b10;

  localparam logic [5:0] REG_ADDR_MAX = 6'd31;
  localparam logic [5:0] MEM_ADDR_MAX = 6'd63;

  // Active-low segments: a lit segment is a 0 bit.
  localparam logic [6:0] HEX_SEG [0:15] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Decoded display source; the unused Mode code 11 falls back to PC.
  typedef enum logic [1:0] {
    SRC_PC  = 2'd0,
    SRC_REG = 2'd1,
    SRC_MEM = 2'd2
  } src_e;

  function automatic src_e to_src(input logic [1:0] mode);
    case (mode)
      MODE_REG: return SRC_REG;
      MODE_MEM: return SRC_MEM;
      default:  return SRC_PC;
    endcase
  endfunction

endpackage

// File: rtl/mips_disp_scanner_hex7seg.sv
// hex7seg
//   Combinational 4-bit to active-low 7-segment lookup.
//   Ports:
//     nibble  in  4  hex digit value
//     seg     out 7  segments gfedcba, active low
module hex7seg
  import mips_disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/mips_disp_scanner.sv
// mips_disp_scanner
//   Board-side consumer of the mips_top debug display port. Drives a 6-bit
//   debug address into the core, captures PC / register / memory data into
//   Shown, and scans Shown onto an 8-digit multiplexed 7-segment display.
//   Optional build macro: DISP_AUTOSCAN_EN adds a dwell timer that advances
//   the address automatically in register/memory mode.
//   Ports:
//     CLK      in   1   clock, all state on rising edge
//     Reset    in   1   synchronous active-high reset
//     Mode     in   2   00=PC, 01=register file, 10=data memory, 11=PC
//     Step     in   1   synchronised button level; rising edge advances
//     PC       in   32  current core PC
//     DispReg  in   32  register-file read data for Disp[4:0]
//     DispMem  in   32  data-memory read data for Disp
//     Disp     out  6   debug address to core (registered)
//     Shown    out  32  displayed word (registered)
//     An       out  8   digit anodes, active low, one-hot-zero
//     Seg      out  7   segments gfedcba, active low
//     Dp       out  1   decimal point, active low
module mips_disp_scanner
  import mips_disp_pkg::*;
#(
  parameter int REFRESH_DIV = 1000,
  parameter int DWELL_CYC   = 50000000
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [1:0]  Mode,
  input  logic        Step,
  input  logic [31:0] PC,
  input  logic [31:0] DispReg,
  input  logic [31:0] DispMem,
  output logic [5:0]  Disp,
  output logic [31:0] Shown,
  output logic [7:0]  An,
  output logic [6:0]  Seg,
  output logic        Dp
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [1:0]    mode_q_reg;
  logic          step_q_reg;
  logic [5:0]    disp_reg, disp_next;
  logic [31:0]   shown_reg, shown_next;
  logic [RW-1:0] refresh_cnt_reg;
  logic [2:0]    idx_reg;
  logic [7:0]    an_reg, an_next;
  logic [6:0]    seg_reg, seg_next;
  logic          dp_reg, dp_next;
  logic [3:0]    nibble;
  logic          step_edge, mode_chg, advance, refresh_tc;
  src_e          src;

  assign src        = to_src(mode_q_reg);
  assign step_edge  = Step & ~step_q_reg;
  assign mode_chg   = (Mode != mode_q_reg);
  assign refresh_tc = (refresh_cnt_reg == RW'(REFRESH_DIV - 1));

`ifdef DISP_AUTOSCAN_EN
  localparam int DW = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;

  logic [DW-1:0] dwell_cnt_reg, dwell_cnt_next;
  logic          dwell_tc;

  assign dwell_tc = (src != SRC_PC) && (dwell_cnt_reg == DW'(DWELL_CYC - 1));
  assign advance  = step_edge | dwell_tc;

  // A manual step restarts the dwell so the user gets a full period on the
  // address they just picked; PC mode keeps the timer parked at zero.
  always_comb begin
    dwell_cnt_next = dwell_cnt_reg + 1'b1;
    if (mode_chg || src == SRC_PC || step_edge || dwell_tc)
      dwell_cnt_next = '0;
  end

  always_ff @(posedge CLK) begin
    if (Reset) dwell_cnt_reg <= '0;
    else       dwell_cnt_reg <= dwell_cnt_next;
  end
`else
  assign advance = step_edge;

  // Without auto-scan the dwell period has no effect.
  if (DWELL_CYC < 2) begin : g_dwell_unused
  end
`endif

  // Address next-state: a mode change always wins and suppresses any advance.
  always_comb begin
    disp_next = disp_reg;
    if (mode_chg) begin
      disp_next = '0;
    end else if (advance) begin
      case (src)
        SRC_REG: disp_next = (disp_reg[4:0] == REG_ADDR_MAX[4:0]) ? 6'd0
                             : {1'b0, disp_reg[4:0] + 5'd1};
        SRC_MEM: disp_next = (disp_reg == MEM_ADDR_MAX) ? 6'd0 : disp_reg + 6'd1;
        default: disp_next = disp_reg;
      endcase
    end
  end

  // Output decode: capture mux plus the digit driven on the next refresh slot.
  always_comb begin
    case (src)
      SRC_REG: shown_next = DispReg;
      SRC_MEM: shown_next = DispMem;
      default: shown_next = PC;
    endcase
    nibble  = shown_reg[4*idx_reg +: 4];
    dp_next = ~((src == SRC_REG && idx_reg == 3'd0) ||
                (src == SRC_MEM && idx_reg == 3'd1));
  end

  for (genvar gi = 0; gi < 8; gi++) begin : g_anode
    assign an_next[gi] = (idx_reg != 3'(gi));
  end

  hex7seg u_hex7seg (
    .nibble (nibble),
    .seg    (seg_next)
  );

  always_ff @(posedge CLK) begin
    if (Reset) begin
      mode_q_reg      <= MODE_PC;
      step_q_reg      <= 1'b0;
      disp_reg        <= '0;
      shown_reg       <= '0;
      refresh_cnt_reg <= '0;
      idx_reg         <= '0;
      an_reg          <= 8'hFE;
      seg_reg         <= 7'h40;
      dp_reg          <= 1'b1;
    end else begin
      mode_q_reg      <= Mode;
      step_q_reg      <= Step;
      disp_reg        <= disp_next;
      shown_reg       <= shown_next;
      refresh_cnt_reg <= refresh_tc ? '0 : refresh_cnt_reg + 1'b1;
      idx_reg         <= refresh_tc ? idx_reg + 3'd1 : idx_reg;
      // Anode and segments update on the same edge so no digit ever shows
      // its neighbour's pattern.
      an_reg          <= an_next;
      seg_reg         <= seg_next;
      dp_reg          <= dp_next;
    end
  end

  assign Disp  = disp_reg;
  assign Shown = shown_reg;
  assign An    = an_reg;
  assign Seg   = seg_reg;
  assign Dp    = dp_reg;

endmodule

// File: tb/tb_mips_disp_scanner.sv
// tb_mips_disp_scanner
//   Directed plus randomized bench for mips_disp_scanner with a small
//   behavioural model (address, capture, refresh position by cycle count).
//   Build with DISP_AUTOSCAN_EN to exercise the auto-scan dwell timer.
module tb_mips_disp_scanner;

  localparam int R = 4;
  localparam int D = 4;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic [1:0]  Mode = 2'b00;
  logic        Step = 1'b0;
  logic [31:0] PC = '0, DispReg = '0, DispMem = '0;
  logic [5:0]  Disp;
  logic [31:0] Shown;
  logic [7:0]  An;
  logic [6:0]  Seg;
  logic        Dp;

  mips_disp_scanner #(.REFRESH_DIV(R), .DWELL_CYC(D)) dut (
    .CLK(CLK), .Reset(Reset), .Mode(Mode), .Step(Step), .PC(PC),
    .DispReg(DispReg), .DispMem(DispMem), .Disp(Disp), .Shown(Shown),
    .An(An), .Seg(Seg), .Dp(Dp)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;
  bit rand_data = 1'b0;

  // Model state
  int          m_disp, m_mode_q, m_dwell, m_cycles;
  bit          m_step_q;
  logic [31:0] m_shown;
  logic [7:0]  m_an;
  logic [6:0]  m_seg;
  logic        m_dp;

  function automatic logic [6:0] seg_of(input int v);
    case (v)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10; 10: return 7'h08; 11: return 7'h03;
      12: return 7'h46; 13: return 7'h21; 14: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  // 0 = PC, 1 = register, 2 = memory; code 3 shows PC.
  function automatic int src_of(input int m);
    return (m == 3) ? 0 : m;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_disp = 0; m_mode_q = 0; m_dwell = 0; m_cycles = 0; m_step_q = 0;
    m_shown = '0; m_an = 8'hFE; m_seg = 7'h40; m_dp = 1'b1;
  endtask

  task automatic tick();
    int digit, s, nd;
    bit edge_s, adv;
    if (rand_data) begin
      PC = $urandom; DispReg = $urandom; DispMem = $urandom;
    end
    @(posedge CLK);
    if (Reset) begin
      model_reset();
    end else begin
      s     = src_of(m_mode_q);
      digit = (m_cycles / R) % 8;
      m_an  = ~(8'h01 << digit);
      m_seg = seg_of(int'(m_shown[4*digit +: 4]));
      m_dp  = !((s == 1 && digit == 0) || (s == 2 && digit == 1));
      m_shown = (s == 1) ? DispReg : (s == 2) ? DispMem : PC;
      edge_s = Step && !m_step_q;
      adv    = edge_s;
      nd     = m_dwell;
`ifdef DISP_AUTOSCAN_EN
      if (int'(Mode) != m_mode_q || s == 0 || edge_s) nd = 0;
      else if (m_dwell == D - 1) begin nd = 0; adv = 1; end
      else nd = m_dwell + 1;
`endif
      m_dwell = nd;
      if (int'(Mode) != m_mode_q) m_disp = 0;
      else if (adv && s == 1) m_disp = (m_disp + 1) % 32;
      else if (adv && s == 2) m_disp = (m_disp + 1) % 64;
      m_mode_q = int'(Mode);
      m_step_q = Step;
      m_cycles++;
    end
    @(negedge CLK);
    chk("disp", 32'(Disp), 32'(m_disp));
    chk("shown", Shown, m_shown);
    chk("an", 32'(An), 32'(m_an));
    chk("seg", 32'(Seg), 32'(m_seg));
    chk("dp", 32'(Dp), 32'(m_dp));
  endtask

  task automatic pulse();
    Step = 1'b1; tick();
    Step = 1'b0; tick();
  endtask

  initial begin
    model_reset();
    // 1: reset
    Reset = 1'b1; Mode = 2'b01;
    tick(); tick();
    chk("rst_an", 32'(An), 32'hFE);
    chk("rst_seg", 32'(Seg), 32'h40);
    Reset = 1'b0;

    // 2: register mode, fixed data, one step, full refresh sweep
    DispReg = 32'h1234ABCD;
    tick(); tick();
    Step = 1'b1; tick();
`ifndef DISP_AUTOSCAN_EN
    chk("t2_disp", 32'(Disp), 32'd1);
`endif
    Step = 1'b0;
    for (int i = 0; i < 8 * R + 4; i++) tick();
    chk("t2_shown", Shown, 32'h1234ABCD);

    // 3: register wrap after 32 steps, memory wrap after 64
    Mode = 2'b10; tick();
    Mode = 2'b01; tick();
    for (int i = 0; i < 32; i++) pulse();
`ifndef DISP_AUTOSCAN_EN
    chk("t3_reg_wrap", 32'(Disp), 32'd0);
`endif
    Mode = 2'b10; tick();
    for (int i = 0; i < 63; i++) pulse();
`ifndef DISP_AUTOSCAN_EN
    chk("t3_mem_max", 32'(Disp), 32'd63);
`endif
    pulse();
`ifndef DISP_AUTOSCAN_EN
    chk("t3_mem_wrap", 32'(Disp), 32'd0);
`endif

    // 4: mode change beats a simultaneous step edge; held step advances once
    for (int i = 0; i < 5; i++) pulse();
    Mode = 2'b01; Step = 1'b1; tick();
    chk("t4_mode_clr", 32'(Disp), 32'd0);
    Step = 1'b0; tick();
    Step = 1'b1;
    for (int i = 0; i < 100; i++) tick();
    Step = 1'b0; tick();
`ifndef DISP_AUTOSCAN_EN
    chk("t4_held", 32'(Disp), 32'd1);
`endif

    // 5: PC mode capture; steps ignored
    Mode = 2'b00; PC = 32'h00400010; tick(); tick();
    chk("t5_pc", Shown, 32'h00400010);
    for (int i = 0; i < 3; i++) pulse();
    chk("t5_hold", 32'(Disp), 32'd0);

`ifdef DISP_AUTOSCAN_EN
    // 6: auto-scan in memory mode, step restart, reset mid-dwell
    Mode = 2'b10;
    for (int i = 0; i < 13; i++) tick();
    tick(); tick();
    pulse();
    for (int i = 0; i < 6; i++) tick();
    Reset = 1'b1; tick();
    Reset = 1'b0;
    for (int i = 0; i < 10; i++) tick();
`endif

    // Randomized soak
    rand_data = 1'b1;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(15) == 0) Mode = 2'($urandom_range(3));
      Step  = ($urandom_range(2) == 0);
      Reset = ($urandom_range(63) == 0);
      tick();
    end
    Reset = 1'b0; Step = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
